// File: rtl/packed_struct_fifo.sv
// First-word-fall-through elastic buffer for 41-bit {valid, tag, data} records with saturating drop counter.
// Optional build macro TAG_SEQ_CHECK_EN adds a sticky tag-sequence error flag.
module packed_struct_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [40:0]       in_rec,
   output logic              in_ready,
   output logic [40:0]       out_rec,
   input  logic              out_ready,
   output logic [ADDR_W:0]   count,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic              seq_err
);

   localparam int unsigned REC_W   = 41;
   localparam int unsigned PAY_W   = REC_W - 1;
   localparam int unsigned CW      = ADDR_W + 1;
   localparam int unsigned TAG_LSB = 32;

   // Only the {tag, data} payload is stored; valid is implied by occupancy.
   logic [PAY_W-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic              push, pop;

   assign in_ready = (count_q != CW'(DEPTH));
   assign out_rec  = (count_q != '0) ? {1'b1, mem_q[rd_ptr_q]} : '0;
   assign count    = count_q;
   assign drop_cnt = drop_cnt_q;

   always_comb begin
      push       = in_rec[REC_W-1] & in_ready;
      pop        = out_rec[REC_W-1] & out_ready;
      wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
      rd_ptr_d   = rd_ptr_q + ADDR_W'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      drop_cnt_d = drop_cnt_q;
      // A write while full is refused even if the head leaves this cycle.
      if (in_rec[REC_W-1] && !in_ready && (drop_cnt_q != '1))
         drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= in_rec[PAY_W-1:0];
   end

`ifdef TAG_SEQ_CHECK_EN
   logic [7:0] last_tag_q, last_tag_d;
   logic       seen_q, seen_d;
   logic       seq_err_q, seq_err_d;
   logic [7:0] in_tag;

   always_comb begin
      in_tag     = in_rec[TAG_LSB +: 8];
      last_tag_d = last_tag_q;
      seen_d     = seen_q;
      seq_err_d  = seq_err_q;
      if (push) begin
         last_tag_d = in_tag;
         seen_d     = 1'b1;
         if (seen_q && (in_tag != last_tag_q + 8'd1))
            seq_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_tag_q <= '0;
         seen_q     <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         last_tag_q <= last_tag_d;
         seen_q     <= seen_d;
         seq_err_q  <= seq_err_d;
      end
   end

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_packed_struct_fifo.sv
// Directed table-driven bench for packed_struct_fifo (DEPTH=4, CNT_W=8), plus reset, saturation and tag-sequence sequences.
module tb_packed_struct_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;
   localparam int unsigned CNT_W = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [40:0]       in_rec;
   logic              in_ready;
   logic [40:0]       out_rec;
   logic              out_ready;
   logic [AW:0]       count;
   logic [CNT_W-1:0]  drop_cnt;
   logic              seq_err;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   packed_struct_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_rec(in_rec), .in_ready(in_ready),
      .out_rec(out_rec), .out_ready(out_ready), .count(count),
      .drop_cnt(drop_cnt), .seq_err(seq_err)
   );

   typedef struct {
      logic        vld;
      logic [7:0]  tag;
      logic [31:0] data;
      logic        ordy;
      logic [40:0] exp_rec;
      logic [AW:0] exp_cnt;
      logic        exp_ir;
      logic [7:0]  exp_drop;
   } vec_t;

   vec_t vq[$];

   function automatic logic [40:0] r(input logic [7:0] t, input logic [31:0] d);
      return {1'b1, t, d};
   endfunction

   task automatic add(input logic v, input logic [7:0] t, input logic [31:0] d, input logic o,
                      input logic [40:0] er, input int ec, input logic ei, input int ed);
      vec_t x;
      x.vld = v; x.tag = t; x.data = d; x.ordy = o;
      x.exp_rec = er; x.exp_cnt = (AW+1)'(ec); x.exp_ir = ei; x.exp_drop = 8'(ed);
      vq.push_back(x);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Drive at negedge, sample 1 time unit after the following rising edge.
   task automatic cyc(input logic v, input logic [7:0] t, input logic [31:0] d, input logic o);
      @(negedge clk);
      in_rec    = v ? {1'b1, t, d} : 41'h0;
      out_ready = o;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_rec = '0; out_ready = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_rec = '0; out_ready = 1'b0;
      #12;
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_rec",  64'(out_rec),  64'd0);
      check("reset count",    64'(count),    64'd0);
      check("reset drop_cnt", 64'(drop_cnt), 64'd0);
      check("reset seq_err",  64'(seq_err),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // basic push, full, drop, drain
      add(0, 8'h00, 32'h0,          0, 41'h0,                      0, 1, 0);
      add(1, 8'h01, 32'hDEADBEEF,   0, r(8'h01, 32'hDEADBEEF),     1, 1, 0);
      add(1, 8'h02, 32'h12345678,   0, r(8'h01, 32'hDEADBEEF),     2, 1, 0);
      add(0, 8'h00, 32'h0,          0, r(8'h01, 32'hDEADBEEF),     2, 1, 0);
      add(1, 8'h03, 32'h33330003,   0, r(8'h01, 32'hDEADBEEF),     3, 1, 0);
      add(1, 8'h04, 32'h44440004,   0, r(8'h01, 32'hDEADBEEF),     4, 0, 0);
      add(1, 8'h05, 32'h55550005,   0, r(8'h01, 32'hDEADBEEF),     4, 0, 1);
      add(0, 8'h00, 32'h0,          1, r(8'h02, 32'h12345678),     3, 1, 1);
      add(0, 8'h00, 32'h0,          1, r(8'h03, 32'h33330003),     2, 1, 1);
      add(0, 8'h00, 32'h0,          1, r(8'h04, 32'h44440004),     1, 1, 1);
      add(0, 8'h00, 32'h0,          1, 41'h0,                      0, 1, 1);
      add(0, 8'h00, 32'h0,          1, 41'h0,                      0, 1, 1);
      // streaming tags 00..09 across pointer wrap
      add(1, 8'h00, 32'hA0000000,   1, r(8'h00, 32'hA0000000),     1, 1, 1);
      for (int k = 1; k < 10; k++)
         add(1, 8'(k), 32'hA0000000 + 32'(k), 1, r(8'(k), 32'hA0000000 + 32'(k)), 1, 1, 1);
      add(0, 8'h00, 32'h0,          1, 41'h0,                      0, 1, 1);
      // full with simultaneous pop and write
      for (int k = 0; k < 4; k++)
         add(1, 8'(8'h20 + k), 32'hC0000020 + 32'(k), 0, r(8'h20, 32'hC0000020), k + 1, (k != 3), 1);
      add(1, 8'h24, 32'hC0000024,   1, r(8'h21, 32'hC0000021),     3, 1, 2);
      add(0, 8'h00, 32'h0,          1, r(8'h22, 32'hC0000022),     2, 1, 2);
      add(0, 8'h00, 32'h0,          1, r(8'h23, 32'hC0000023),     1, 1, 2);
      add(0, 8'h00, 32'h0,          1, 41'h0,                      0, 1, 2);

      foreach (vq[i]) begin
         cyc(vq[i].vld, vq[i].tag, vq[i].data, vq[i].ordy);
         check($sformatf("v%0d out_rec", i),  64'(out_rec),  64'(vq[i].exp_rec));
         check($sformatf("v%0d count", i),    64'(count),    64'(vq[i].exp_cnt));
         check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vq[i].exp_ir));
         check($sformatf("v%0d drop_cnt", i), 64'(drop_cnt), 64'(vq[i].exp_drop));
`ifndef TAG_SEQ_CHECK_EN
         check($sformatf("v%0d seq_err", i),  64'(seq_err),  64'd0);
`endif
      end

      // reset mid-operation clears state asynchronously
      cyc(1, 8'h31, 32'h31313131, 0);
      cyc(1, 8'h32, 32'h32323232, 0);
      check("mid count before reset", 64'(count), 64'd2);
      @(negedge clk);
      in_rec = '0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst count",    64'(count),    64'd0);
      check("async rst out_rec",  64'(out_rec),  64'd0);
      check("async rst in_ready", 64'(in_ready), 64'd1);
      check("async rst drop_cnt", 64'(drop_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1, 8'h40, 32'h40404040, 0);
      check("post rst head",  64'(out_rec), 64'(r(8'h40, 32'h40404040)));
      check("post rst count", 64'(count),   64'd1);
      cyc(0, 8'h00, 32'h0, 1);
      check("post rst drain", 64'(out_rec), 64'd0);

      // drop counter saturation
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 8'(k), 32'(k), 0);
      for (int k = 4; k < 304; k++) cyc(1, 8'(k), 32'(k), 0);
      check("sat drop_cnt", 64'(drop_cnt), 64'd255);
      check("sat count",    64'(count),    64'd4);
      check("sat head",     64'(out_rec),  64'(r(8'h00, 32'h0)));

`ifdef TAG_SEQ_CHECK_EN
      do_reset();
      cyc(1, 8'h10, 32'h10, 0);
      cyc(1, 8'h11, 32'h11, 0);
      check("seq ok after 10,11", 64'(seq_err), 64'd0);
      cyc(1, 8'h13, 32'h13, 0);
      check("seq err after 13", 64'(seq_err), 64'd1);
      check("seq 13 stored",    64'(count),   64'd3);
      cyc(0, 8'h00, 32'h0, 1);
      cyc(0, 8'h00, 32'h0, 0);
      check("seq err sticky", 64'(seq_err), 64'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("seq err async clear", 64'(seq_err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
